// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - size encodings, FSM state constants and mask helpers for the load/store unit
package mem_access_unit_pkg;

    // Access size encodings carried on lsu_size_i
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Byte-enable pattern for an access of the given size starting at lane 0
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return 8'h01;
            SIZE_H:  return 8'h03;
            SIZE_W:  return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // True when the low address bits are not a multiple of the access size
    function automatic logic misaligned(input logic [2:0] offset, input logic [1:0] size);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            SIZE_W:  return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - load data lane shift, size truncation and sign/zero extension
//
// Ports:
//   rdata       in  XLEN  8-byte aligned data returned by the bus
//   offset      in  3     byte offset of the access inside the doubleword
//   size        in  2     access size (byte/half/word/double)
//   is_unsigned in  1     1 zero-extends, 0 sign-extends
//   result      out XLEN  right-justified, extended load value
module lsu_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (size)
            SIZE_B: result = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                         : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            SIZE_H: result = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                         : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            SIZE_W: result = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                         : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit with req/gnt/rvalid data bus and pipeline stall
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN (size-misaligned accesses skip the bus and flag misalign_o)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   lsu_valid_i/ld_i/st_i live memory op from EX/MEM (load or store)
//   lsu_size_i            0 byte, 1 half, 2 word, 3 double
//   lsu_unsigned_i        load zero-extends when set
//   lsu_addr_i/wdata_i    effective address, right-justified store data
//   dmem_*_o              bus request, write enable, aligned address, lane-shifted data, byte mask
//   dmem_gnt_i            bus accepted the request
//   dmem_rvalid_i/rdata_i load data return
//   stall_o               hold IF..MEM while the access is outstanding
//   mem_done_o            memory op completes this cycle
//   from_mem_alu_res_o    last load result for MEM/WB
//   misalign_o            misaligned access flagged (0 unless the macro is defined)
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lsu_valid_i,
    input  logic            lsu_ld_i,
    input  logic            lsu_st_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_unsigned_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    output logic [7:0]      dmem_wmask_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic            mem_done_o,
    output logic [XLEN-1:0] from_mem_alu_res_o,
    output logic            misalign_o
);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] load_res;
    logic [1:0]      size_q;
    logic            uns_q;
    logic            st_q;
    logic            start;
    logic            bad_addr;
    logic            in_req;

    assign start  = lsu_valid_i & (lsu_ld_i | lsu_st_i);
    assign in_req = (state_q == ST_REQ);

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q;

    assign bad_addr   = misaligned(lsu_addr_i[2:0], lsu_size_i);
    assign misalign_o = (state_q == ST_DONE) & misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            misalign_q <= start & bad_addr;
        end
    end
`else
    assign bad_addr   = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = bad_addr ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem_gnt_i) state_d = st_q ? ST_DONE : ST_WAIT;
            // rvalid is only looked at here, so a stray rvalid during REQ is ignored
            ST_WAIT: if (dmem_rvalid_i) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    lsu_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata      (dmem_rdata_i),
        .offset     (addr_q[2:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .result     (load_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            size_q   <= SIZE_B;
            uns_q    <= 1'b0;
            st_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                addr_q  <= lsu_addr_i;
                wdata_q <= lsu_wdata_i;
                size_q  <= lsu_size_i;
                uns_q   <= lsu_unsigned_i;
                st_q    <= lsu_st_i;
            end
            if (state_q == ST_WAIT && dmem_rvalid_i) begin
                result_q <= load_res;
            end
        end
    end

    // Bus outputs come from the captured registers and are forced to zero outside REQ,
    // so they stay stable while waiting for gnt and are quiet after reset.
    // The mask shift keeps 8 bits: lanes past the doubleword boundary are dropped.
    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req & st_q;
    assign dmem_addr_o  = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
    assign dmem_wdata_o = in_req ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;
    assign dmem_wmask_o = in_req ? (size_mask(size_q) << addr_q[2:0]) : 8'h00;

    assign stall_o            = in_req | (state_q == ST_WAIT) | ((state_q == ST_IDLE) & start);
    assign mem_done_o         = (state_q == ST_DONE);
    assign from_mem_alu_res_o = result_q;

endmodule
